// File: rtl/config_bus_arbiter.sv
// ---------------------------------------------------------------------------
// config_bus_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share one configuration
// write bus. A requester is granted while the arbiter is idle. Its
// {addr, payload} message is latched and presented for exactly one cycle as a
// write on cfg_msg. The bus then idles for GAP_CYCLES cycles before the next
// grant can be made.
//
// Ports
//   clk          in   single clock, rising-edge active
//   reset        in   asynchronous, active-high reset
//   req_msg      in   NUM_REQ x {addr, payload}; slice i belongs to requester i
//   req_val      in   per-requester valid
//   req_rdy      out  per-requester ready (one-hot on the winner in IDLE)
//   cfg_msg      out  config bus {addr, wen, payload}
//   done_val     out  one-cycle pulse while a write is on the bus
//   done_id      out  index of the requester whose write is on the bus
//   busy         out  high whenever the FSM is not IDLE
//   write_count  out  free-running, wrapping count of issued writes
// ---------------------------------------------------------------------------
module config_bus_arbiter #(
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8,
    parameter int NUM_REQ      = 4,   // legal range 2..8
    parameter int GAP_CYCLES   = 1    // legal range 0..15
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQ*(ADDR_SIZE+PAYLOAD_SIZE)-1:0]  req_msg,
    input  logic [NUM_REQ-1:0]                           req_val,
    output logic [NUM_REQ-1:0]                           req_rdy,
    output logic [ADDR_SIZE+PAYLOAD_SIZE:0]              cfg_msg,
    output logic                                         done_val,
    output logic [$clog2(NUM_REQ)-1:0]                   done_id,
    output logic                                         busy,
    output logic [15:0]                                  write_count
);

    localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE;
    localparam int ID_W  = $clog2(NUM_REQ);

    // The gap counter is loaded with GAP_CYCLES-1 so that the GAP state lasts
    // exactly GAP_CYCLES cycles. With GAP_CYCLES == 0 the GAP state is never
    // entered, so the load value does not matter.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ID_W-1:0]         ptr;
    logic [3:0]              gap_cnt;

    // Registered config bus fields. They are kept separate so that addr and
    // payload can hold their values while wen drops after the issue cycle.
    logic [ADDR_SIZE-1:0]    cfg_addr;
    logic                    cfg_wen;
    logic [PAYLOAD_SIZE-1:0] cfg_payload;

    // Arbitration results
    logic                    grant_found;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         ptr_next;
    logic [MSG_W-1:0]        grant_msg;
    logic                    transfer;

    // -----------------------------------------------------------------------
    // Round-robin search: the first set req_val at or after ptr, searching
    // upward and wrapping. The modulo keeps the search correct for
    // requester counts that are not a power of two.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first. Otherwise a path that skips the assignment infers a latch.
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_val[(int'(ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        grant_msg = req_msg[int'(grant_id)*MSG_W +: MSG_W];
    end

    // A grant can only be made in IDLE. The winner always has req_val set,
    // so a ready on the winner always completes a transfer. A requester
    // that drops req_val before this point is simply never seen.
    assign transfer = (state == IDLE) && grant_found && !reset;

    // req_rdy is combinational so that the handshake completes in the same
    // cycle. It is gated by reset so that no transfer can appear to happen
    // while reset is held.
    always_comb begin
        req_rdy = '0;
        if (transfer) begin
            req_rdy = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register and next-state logic
    // -----------------------------------------------------------------------
    // NOTE: reset is in the sensitivity list, so it takes effect immediately
    // without waiting for a clock edge. This is how an in-flight write gets
    // dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the values from before the edge.
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: the grant pointer, the registered bus outputs, the write
    // counter and the gap counter.
    // The bus registers are loaded on the transfer edge, so the write is
    // visible for the whole ISSUE cycle. On the edge that leaves ISSUE, wen
    // and done_val are cleared and the write is counted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            cfg_addr    <= '0;
            cfg_wen     <= 1'b0;
            cfg_payload <= '0;
            done_val    <= 1'b0;
            done_id     <= '0;
            write_count <= 16'd0;
            gap_cnt     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        ptr         <= ptr_next;
                        cfg_addr    <= grant_msg[MSG_W-1 -: ADDR_SIZE];
                        cfg_payload <= grant_msg[PAYLOAD_SIZE-1:0];
                        cfg_wen     <= 1'b1;
                        done_val    <= 1'b1;
                        done_id     <= grant_id;
                    end
                end
                ISSUE: begin
                    cfg_wen     <= 1'b0;
                    done_val    <= 1'b0;
                    write_count <= write_count + 16'd1;   // wraps 16'hFFFF -> 0
                    gap_cnt     <= GAP_LOAD;
                end
                GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    cfg_wen  <= 1'b0;
                    done_val <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cfg_msg = {cfg_addr, cfg_wen, cfg_payload};
    assign busy    = (state != IDLE);

endmodule
